ir_fetch_decode: RTL and testbench
==================================

Name: ir_fetch_decode

Overview:
Front-end stage feeding the instruction queue (iq) over the IQ_2_IR signal set. It keeps the PC and fetches one 32-bit word at a time from the instruction memory port. It decodes each word into a tomasula_types::ctl_word and offers it to iq with a hold-until-ack handshake. It also accepts a redirect (flush) from the branch unit and discards any in-flight fetch.

Parameters:
PC_RESET, 32'h4000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
imem_address  out  32  fetch address, always the current PC, word aligned.
imem_read  out  1  fetch request; held high until imem_resp.
imem_rdata  in  32  fetched instruction; valid when imem_resp=1.
imem_resp  in  1  single-cycle fetch completion.
ld_iq  out  1  control_word is valid; drives IQ_2_IR ld_iq.
control_word  out  ctl_word  decoded instruction; drives IQ_2_IR control_word.
ack_o  in  1  iq accepted the word this cycle; from IQ_2_IR ack_o.
flush_i  in  1  redirect request from the branch unit.
flush_pc  in  32  redirect target; valid with flush_i.
illegal_o  out  1  one-cycle pulse when a fetched word has an unsupported opcode.

Behaviour:
- One clock. Reset is synchronous and active-high: clk, rst.
- Reset, and reset mid-operation:
  - State becomes FETCH and PC becomes PC_RESET.
  - ld_iq=0, illegal_o=0, control_word=all zeros.
  - imem_read is 0 in the reset cycle and is asserted from the first cycle after rst deasserts.
  - Any outstanding memory response is not tracked across reset.
- FSM states FETCH, ISSUE, DRAIN:
  - FETCH: imem_read=1, imem_address=PC.
    - On imem_resp with a legal opcode: latch the decoded word, go to ISSUE. ld_iq=1 from the next cycle.
    - On imem_resp with an illegal opcode: pulse illegal_o next cycle, PC+=4, stay in FETCH.
  - ISSUE: ld_iq=1. control_word is held stable until ack_o.
    - On ack_o: PC+=4, go to FETCH, ld_iq=0 next cycle.
    - Minimum spacing is 3 cycles per instruction with 1-cycle memory.
  - DRAIN: imem_read stays 1. On imem_resp the data is discarded and the state goes to FETCH; PC was already set to flush_pc.
- Flush has priority over every other event:
  - In FETCH without imem_resp the same cycle: PC←flush_pc, go to DRAIN.
  - In FETCH with imem_resp the same cycle: discard the data, PC←flush_pc, stay in FETCH.
  - In ISSUE, including a cycle where ack_o=1: PC←flush_pc, ld_iq=0 next cycle, go to FETCH. Discarding anything iq already accepted is iq's responsibility.
  - In DRAIN: PC←flush_pc, stay in DRAIN.
- Decode into ctl_word:
  - rd=instr[11:7], funct3=instr[14:12], funct7=instr[30], pc=fetch PC.
  - src1_reg=instr[19:15], src2_reg=instr[24:20].
  - src1_valid: 1 if rs1 is read (JALR, BRANCH, LOAD, STORE, OP-IMM, OP).
  - src2_valid: 1 if rs2 is read (BRANCH, STORE, OP). When 0, src2_data holds the sign-extended immediate (I/S/B/U/J format by opcode). When 1, src2_data holds the immediate for BRANCH/STORE and 0 for OP.
  - rd is forced to 0 for BRANCH/STORE.
  - Opcode to op: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011/0110011 ARITH. Anything else is illegal.
- Arithmetic: PC+4 wraps modulo 2^32. imem_address[1:0] is always 0; flush_pc[1:0] is ignored.

Decomposition:
- The op enum (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, ARITH) and ctl_word live in tomasula_types.
- Opcode constants and the FSM state enum go in rv32i_types.
- One combinational sub-module, rv32i_decoder (instr, pc → ctl_word, illegal), so iq-side benches can reuse it.

Test Plan:
- Reset, imem_resp 1 cycle after each read, ack_o on the first ld_iq cycle, memory holds ADDI x1,x0,5 at 0x40000000 → control_word op=ARITH, rd=1, src1_valid=1, src2_valid=0, src2_data=5, pc=0x40000000. Next imem_address=0x40000004.
- ack_o held low for 10 cycles in ISSUE → ld_iq stays 1, control_word is unchanged, imem_read=0, PC is unchanged.
- BEQ x1,x2,-8 fetched → op=BRANCH, src1_valid=src2_valid=1, src2_data=32'hFFFF_FFF8, rd=0.
- flush_i with flush_pc=0x40000100 while a fetch is outstanding (no resp) → state goes to DRAIN; the next response is discarded (no ld_iq); the following read is at 0x40000100.
- flush_i in the same cycle as ack_o → ld_iq=0 next cycle, next fetch at flush_pc (not PC+4).
- Fetched word 0x0000007F → illegal_o pulses once, no ld_iq, next fetch at PC+4. Then assert rst for one cycle mid-ISSUE → ld_iq=0 and the first post-reset imem_address=0x40000000.

Source files
------------

// File: rtl/ir_fetch_decode_pkg.sv
// Shared types for the fetch/decode front end: the control word handed to iq,
// plus RV32I opcode constants and the fetch FSM state encoding.
package tomasula_types;

    typedef enum logic [2:0] {
        LUI,
        AUIPC,
        JAL,
        JALR,
        BRANCH,
        LOAD,
        STORE,
        ARITH
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7;
        logic [4:0]  src1_reg;
        logic        src1_valid;
        logic [4:0]  src2_reg;
        logic        src2_valid;
        logic [31:0] src2_data;
    } ctl_word;

endpackage

package rv32i_types;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        DRAIN
    } fsm_state_t;

endpackage

// File: rtl/ir_fetch_decode_decoder.sv
// Combinational RV32I decoder: one instruction word and its PC in, one
// control word and an illegal-opcode flag out.
module rv32i_decoder
    import tomasula_types::*;
    import rv32i_types::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output ctl_word     cw,
    output logic        illegal
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        cw            = '0;
        cw.op         = ARITH;
        cw.pc         = pc;
        cw.rd         = instr[11:7];
        cw.funct3     = instr[14:12];
        cw.funct7     = instr[30];
        cw.src1_reg   = instr[19:15];
        cw.src2_reg   = instr[24:20];
        cw.src1_valid = 1'b0;
        cw.src2_valid = 1'b0;
        cw.src2_data  = 32'h0;
        illegal       = 1'b0;

        case (instr[6:0])
            OPC_LUI: begin
                cw.op        = LUI;
                cw.src2_data = imm_u;
            end
            OPC_AUIPC: begin
                cw.op        = AUIPC;
                cw.src2_data = imm_u;
            end
            OPC_JAL: begin
                cw.op        = JAL;
                cw.src2_data = imm_j;
            end
            OPC_JALR: begin
                cw.op         = JALR;
                cw.src1_valid = 1'b1;
                cw.src2_data  = imm_i;
            end
            OPC_BRANCH: begin
                cw.op         = BRANCH;
                cw.rd         = 5'd0;
                cw.src1_valid = 1'b1;
                cw.src2_valid = 1'b1;
                cw.src2_data  = imm_b;
            end
            OPC_LOAD: begin
                cw.op         = LOAD;
                cw.src1_valid = 1'b1;
                cw.src2_data  = imm_i;
            end
            OPC_STORE: begin
                cw.op         = STORE;
                cw.rd         = 5'd0;
                cw.src1_valid = 1'b1;
                cw.src2_valid = 1'b1;
                cw.src2_data  = imm_s;
            end
            OPC_OPIMM: begin
                cw.op         = ARITH;
                cw.src1_valid = 1'b1;
                cw.src2_data  = imm_i;
            end
            OPC_OP: begin
                cw.op         = ARITH;
                cw.src1_valid = 1'b1;
                cw.src2_valid = 1'b1;
            end
            default: begin
                cw      = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/ir_fetch_decode.sv
// Fetch/decode front end: owns the PC, fetches one word at a time, decodes it
// and holds the control word for iq until acknowledged; branch redirects win.
//
// state | meaning
// FETCH | read request up at PC, waiting for imem_resp
// ISSUE | control word offered to iq (ld_iq=1), waiting for ack_o
// DRAIN | redirected mid-fetch; swallow the stale response, PC already updated
module ir_fetch_decode
    import tomasula_types::*;
    import rv32i_types::*;
#(
    parameter logic [31:0] PC_RESET = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output logic        ld_iq,
    output ctl_word     control_word,
    input  logic        ack_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc,
    output logic        illegal_o
);

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    fsm_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    ctl_word     cw_q, cw_d;
    logic        illegal_q, illegal_d;

    ctl_word     dec_cw;
    logic        dec_illegal;
    logic [31:0] pc_next;
    logic [31:0] redirect_pc;

    rv32i_decoder u_decoder (
        .instr   (imem_rdata),
        .pc      (pc_q),
        .cw      (dec_cw),
        .illegal (dec_illegal)
    );

    assign pc_next     = pc_q + 32'd4;
    assign redirect_pc = flush_pc & ALIGN_MASK;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cw_d      = cw_q;
        illegal_d = 1'b0;

        case (state_q)
            FETCH: begin
                if (flush_i) begin
                    pc_d = redirect_pc;
                    if (!imem_resp) state_d = DRAIN;
                end else if (imem_resp) begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                        pc_d      = pc_next;
                    end else begin
                        cw_d    = dec_cw;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // iq may already have taken the word on a flush+ack cycle; it discards it
                if (flush_i) begin
                    pc_d    = redirect_pc;
                    state_d = FETCH;
                end else if (ack_o) begin
                    pc_d    = pc_next;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (flush_i) begin
                    pc_d = redirect_pc;
                end else if (imem_resp) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= PC_RESET & ALIGN_MASK;
            cw_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cw_q      <= cw_d;
            illegal_q <= illegal_d;
        end
    end

    assign imem_address = pc_q & ALIGN_MASK;
    assign imem_read    = !rst && (state_q == FETCH || state_q == DRAIN);
    assign ld_iq        = (state_q == ISSUE);
    assign control_word = cw_q;
    assign illegal_o    = illegal_q;

endmodule

// File: tb/tb_ir_fetch_decode.sv
// Directed bench for ir_fetch_decode: memory responses, acks and flushes are
// driven cycle by cycle and outputs compared against hand-computed values.
module tb_ir_fetch_decode;
    import tomasula_types::*;

    localparam logic [31:0] W_ADDI  = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] W_BEQ   = 32'hFE20_8CE3;  // beq x1,x2,-8
    localparam logic [31:0] W_ILLEG = 32'h0000_007F;

    logic        clk;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        ld_iq;
    ctl_word     control_word;
    logic        ack_o;
    logic        flush_i;
    logic [31:0] flush_pc;
    logic        illegal_o;

    int n_chk;
    int n_fail;

    ir_fetch_decode #(.PC_RESET(32'h4000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ld_iq        (ld_iq),
        .control_word (control_word),
        .ack_o        (ack_o),
        .flush_i      (flush_i),
        .flush_pc     (flush_pc),
        .illegal_o    (illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in FETCH with the read just issued; memory answers one cycle later.
    task automatic mem_reply(input logic [31:0] word);
        step();
        imem_resp  = 1'b1;
        imem_rdata = word;
        step();
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst        = 1'b1;
        imem_rdata = 32'h0;
        imem_resp  = 1'b0;
        ack_o      = 1'b0;
        flush_i    = 1'b0;
        flush_pc   = 32'h0;

        step();
        check_eq("rst_read", {31'b0, imem_read}, 32'd0);
        check_eq("rst_ld_iq", {31'b0, ld_iq}, 32'd0);
        check_eq("rst_illegal", {31'b0, illegal_o}, 32'd0);
        check_eq("rst_cw_pc", control_word.pc, 32'h0);
        check_eq("rst_cw_data", control_word.src2_data, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_read", {31'b0, imem_read}, 32'd1);
        check_eq("post_rst_addr", imem_address, 32'h4000_0000);

        // ADDI x1,x0,5
        mem_reply(W_ADDI);
        check_eq("addi_ld_iq", {31'b0, ld_iq}, 32'd1);
        check_eq("addi_op", {29'b0, control_word.op}, {29'b0, ARITH});
        check_eq("addi_rd", {27'b0, control_word.rd}, 32'd1);
        check_eq("addi_s1v", {31'b0, control_word.src1_valid}, 32'd1);
        check_eq("addi_s2v", {31'b0, control_word.src2_valid}, 32'd0);
        check_eq("addi_data", control_word.src2_data, 32'd5);
        check_eq("addi_pc", control_word.pc, 32'h4000_0000);
        check_eq("issue_read", {31'b0, imem_read}, 32'd0);

        // Stall in ISSUE: everything must hold
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("stall_ld_iq", {31'b0, ld_iq}, 32'd1);
            check_eq("stall_data", control_word.src2_data, 32'd5);
            check_eq("stall_rd", {27'b0, control_word.rd}, 32'd1);
            check_eq("stall_read", {31'b0, imem_read}, 32'd0);
            check_eq("stall_addr", imem_address, 32'h4000_0000);
        end

        ack_o = 1'b1;
        step();
        ack_o = 1'b0;
        check_eq("ack_ld_iq", {31'b0, ld_iq}, 32'd0);
        check_eq("ack_read", {31'b0, imem_read}, 32'd1);
        check_eq("ack_addr", imem_address, 32'h4000_0004);

        // BEQ x1,x2,-8
        mem_reply(W_BEQ);
        check_eq("beq_ld_iq", {31'b0, ld_iq}, 32'd1);
        check_eq("beq_op", {29'b0, control_word.op}, {29'b0, BRANCH});
        check_eq("beq_s1v", {31'b0, control_word.src1_valid}, 32'd1);
        check_eq("beq_s2v", {31'b0, control_word.src2_valid}, 32'd1);
        check_eq("beq_data", control_word.src2_data, 32'hFFFF_FFF8);
        check_eq("beq_rd", {27'b0, control_word.rd}, 32'd0);
        check_eq("beq_s1", {27'b0, control_word.src1_reg}, 32'd1);
        check_eq("beq_s2", {27'b0, control_word.src2_reg}, 32'd2);
        check_eq("beq_pc", control_word.pc, 32'h4000_0004);

        // Flush coincident with ack: redirect wins over PC+4, low bits dropped
        ack_o    = 1'b1;
        flush_i  = 1'b1;
        flush_pc = 32'h4000_0203;
        step();
        ack_o    = 1'b0;
        flush_i  = 1'b0;
        check_eq("fack_ld_iq", {31'b0, ld_iq}, 32'd0);
        check_eq("fack_read", {31'b0, imem_read}, 32'd1);
        check_eq("fack_addr", imem_address, 32'h4000_0200);

        // Flush with a fetch outstanding -> DRAIN, stale response dropped
        step();
        flush_i  = 1'b1;
        flush_pc = 32'h4000_0100;
        step();
        flush_i  = 1'b0;
        check_eq("drain_read", {31'b0, imem_read}, 32'd1);
        check_eq("drain_addr", imem_address, 32'h4000_0100);
        check_eq("drain_ld_iq", {31'b0, ld_iq}, 32'd0);
        imem_resp  = 1'b1;
        imem_rdata = W_ADDI;
        step();
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        check_eq("drop_ld_iq", {31'b0, ld_iq}, 32'd0);
        check_eq("drop_read", {31'b0, imem_read}, 32'd1);
        check_eq("drop_addr", imem_address, 32'h4000_0100);
        step();
        check_eq("drop_ld_iq2", {31'b0, ld_iq}, 32'd0);
        check_eq("drop_addr2", imem_address, 32'h4000_0100);

        // Illegal opcode: one-cycle pulse, skip to PC+4
        mem_reply(W_ILLEG);
        check_eq("ill_pulse", {31'b0, illegal_o}, 32'd1);
        check_eq("ill_ld_iq", {31'b0, ld_iq}, 32'd0);
        check_eq("ill_read", {31'b0, imem_read}, 32'd1);
        check_eq("ill_addr", imem_address, 32'h4000_0104);
        step();
        check_eq("ill_once", {31'b0, illegal_o}, 32'd0);
        check_eq("ill_ld_iq2", {31'b0, ld_iq}, 32'd0);

        // Reset in the middle of ISSUE
        mem_reply(W_ADDI);
        check_eq("pre_rst_ld_iq", {31'b0, ld_iq}, 32'd1);
        check_eq("pre_rst_pc", control_word.pc, 32'h4000_0104);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_read", {31'b0, imem_read}, 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("mrst_ld_iq", {31'b0, ld_iq}, 32'd0);
        check_eq("mrst_cw_data", control_word.src2_data, 32'h0);
        check_eq("mrst_cw_pc", control_word.pc, 32'h0);
        check_eq("mrst_read", {31'b0, imem_read}, 32'd1);
        check_eq("mrst_addr", imem_address, 32'h4000_0000);

        // Flush on the same cycle as a response in FETCH: data discarded, no DRAIN
        step();
        imem_resp  = 1'b1;
        imem_rdata = W_ADDI;
        flush_i    = 1'b1;
        flush_pc   = 32'h4000_0300;
        step();
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        flush_i    = 1'b0;
        check_eq("fresp_ld_iq", {31'b0, ld_iq}, 32'd0);
        check_eq("fresp_addr", imem_address, 32'h4000_0300);
        check_eq("fresp_read", {31'b0, imem_read}, 32'd1);
        // Still in FETCH: a response now is accepted directly
        imem_resp  = 1'b1;
        imem_rdata = W_ADDI;
        step();
        imem_resp  = 1'b0;
        imem_rdata = 32'h0;
        check_eq("fresp_next_ld", {31'b0, ld_iq}, 32'd1);
        check_eq("fresp_next_pc", control_word.pc, 32'h4000_0300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
